// File: rtl/logic_unit_seq_if.sv
// Request/response channel of the sliced bitwise logic unit.
// The result signal is named final_val because "final" is a reserved word in SystemVerilog.
interface logic_unit_seq_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] final_val;
    logic              zero;

    modport master (
        output in_valid, op, x, y, out_ready,
        input  in_ready, out_valid, final_val, zero
    );

    modport slave (
        input  in_valid, op, x, y, out_ready,
        output in_ready, out_valid, final_val, zero
    );
endinterface

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: one SLICE_W slice of the result per BUSY cycle, LSB first,
// with valid/ready on both sides and the result held under backpressure.
module logic_unit_seq #(
    parameter int DATA_W  = 64,
    parameter int SLICE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_unit_seq_if.slave    bus
);
    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_q;
    logic [DATA_W-1:0]  x_q, y_q, fin_q, fin_nxt;
    logic               zero_q;
    logic [SLICE_W-1:0] xs, ys, fs;
    logic               accept, last;

    assign accept = (state == IDLE) && bus.in_valid;
    assign last   = (cnt == CNT_W'(NSLICE - 1));

    assign xs = x_q[cnt*SLICE_W +: SLICE_W];
    assign ys = y_q[cnt*SLICE_W +: SLICE_W];

    always_comb begin
        fs = '0;
        case (op_q)
            2'b00: fs = xs & ys;
            2'b01: fs = xs | ys;
            2'b10: fs = xs ^ ys;
            2'b11: fs = xs & ~ys;
            default: fs = '0;
        endcase
    end

    // Result with the current slice merged in; zero flag is taken from this on the last slice.
    always_comb begin
        fin_nxt = fin_q;
        fin_nxt[cnt*SLICE_W +: SLICE_W] = fs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = BUSY;
            BUSY:    if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            fin_q  <= '0;
            zero_q <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            op_q   <= bus.op;
            x_q    <= bus.x;
            y_q    <= bus.y;
            fin_q  <= '0;
            zero_q <= 1'b0;
        end else if (state == BUSY) begin
            fin_q <= fin_nxt;
            // Counter parks at NSLICE-1; it is reloaded on the next accept.
            if (last) zero_q <= (fin_nxt == '0);
            else      cnt    <= cnt + 1'b1;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.final_val = fin_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed and randomized bench for logic_unit_seq against a whole-word reference model.
module tb_logic_unit_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nchk = 0;
    int   npass = 0;

    always #5 clk = ~clk;

    logic_unit_seq_if #(.DATA_W(64)) bus();

    logic_unit_seq #(.DATA_W(64), .SLICE_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return a & ~b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Full transaction; operands are scrambled right after accept to prove they were latched.
    task automatic do_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b, input int hold);
        logic [63:0] exp;
        int lat;
        exp = model(o, a, b);
        bus.op = o; bus.x = a; bus.y = b;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        chk("acc_rdy", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.x  = {$urandom, $urandom};
        bus.y  = {$urandom, $urandom};
        bus.op = 2'($urandom_range(0, 3));
        chk("busy_rdy", 64'(bus.in_ready), 64'd0);
        chk("clr", bus.final_val, 64'd0);
        wait_valid(lat);
        chk("latency", 64'(lat), 64'd4);
        chk("final", bus.final_val, exp);
        chk("zero", 64'(bus.zero), 64'(exp == 64'd0));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_vld", 64'(bus.out_valid), 64'd1);
            chk("hold_fin", bus.final_val, exp);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("drain_vld", 64'(bus.out_valid), 64'd0);
        chk("drain_rdy", 64'(bus.in_ready), 64'd1);
        chk("retain", bus.final_val, exp);
    endtask

    initial begin
        int lat;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = 2'b00; bus.x = '0; bus.y = '0;

        #12;
        chk("rst_rdy", 64'(bus.in_ready), 64'd1);
        chk("rst_vld", 64'(bus.out_valid), 64'd0);
        chk("rst_fin", bus.final_val, 64'd0);
        chk("rst_zero", 64'(bus.zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_op(2'b00, 64'd0, 64'd0, 0);
        do_op(2'b00, 64'h133456784ACBCF77, 64'hFEECB2098755D301, 0);
        do_op(2'b10, '1, '1, 1);
        do_op(2'b01, 64'h1, 64'h8000000000000000, 0);

        // Backpressure with a second request queued behind the held result.
        bus.op = 2'b11; bus.x = '1; bus.y = 64'h00000000FFFFFFFF;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_lat", 64'(lat), 64'd4);
        bus.op = 2'b00; bus.x = 64'hF0F0F0F0F0F0F0F0; bus.y = 64'hFF00FF00FF00FF00;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_fin", bus.final_val, 64'hFFFFFFFF00000000);
            chk("bp_vld", 64'(bus.out_valid), 64'd1);
            chk("bp_rdy", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_drain", 64'(bus.out_valid), 64'd0);
        chk("bp_idle", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("q_acc", 64'(bus.in_ready), 64'd0);
        wait_valid(lat);
        chk("q_lat", 64'(lat), 64'd4);
        chk("q_fin", bus.final_val, 64'hF000F000F000F000);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Asynchronous reset two cycles into an operation.
        bus.op = 2'b01; bus.x = 64'h123456789ABCDEF0; bus.y = 64'h0F0F0F0F0F0F0F0F;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_vld", 64'(bus.out_valid), 64'd0);
        chk("ar_fin", bus.final_val, 64'd0);
        chk("ar_rdy", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_op(2'b00, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 0);

        for (int i = 0; i < 24; i++) begin
            logic [63:0] a, b;
            a = {$urandom, $urandom};
            b = (i % 4 == 3) ? a : {$urandom, $urandom};
            do_op(2'($urandom_range(0, 3)), a, b, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
